// File: rtl/reg_list_sequencer.sv
// Block-transfer sequencer: walks a 16-bit register bitmap lowest-first, one register per accepted memory beat.
// Optional macro REG_LIST_SEQUENCER_ABORT_EN adds an abort input that cancels a sequence in BASE or XFER.
module reg_list_sequencer #(
    parameter int WORD_BYTES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] reg_list,
    input  logic [3:0]  base_reg,
    input  logic        is_load,
    input  logic        writeback,
    input  logic        mem_ready,
`ifdef REG_LIST_SEQUENCER_ABORT_EN
    input  logic        abort,
`endif
    output logic [2:0]  mux_a_sel,
    output logic [3:0]  reg_addr,
    output logic        xfer_valid,
    output logic        rf_write,
    output logic [6:0]  addr_offset,
    output logic        busy,
    output logic        base_wb,
    output logic        done
);

    typedef enum logic [2:0] {S_IDLE, S_BASE, S_XFER, S_WB, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] list_q, list_d;
    logic [3:0]  base_q, base_d;
    logic        load_q, load_d;
    logic        wb_q, wb_d;
    logic [6:0]  offset_q, offset_d;
    logic [3:0]  cur_idx;
    logic        abort_w;

`ifdef REG_LIST_SEQUENCER_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // Lowest set bit of the remaining list is the register on the bus.
    always_comb begin
        cur_idx = 4'd0;
        for (int i = 15; i >= 0; i--)
            if (list_q[i]) cur_idx = 4'(i);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            list_q   <= 16'd0;
            base_q   <= 4'd0;
            load_q   <= 1'b0;
            wb_q     <= 1'b0;
            offset_q <= 7'd0;
        end else begin
            state_q  <= state_d;
            list_q   <= list_d;
            base_q   <= base_d;
            load_q   <= load_d;
            wb_q     <= wb_d;
            offset_q <= offset_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        list_d   = list_q;
        base_d   = base_q;
        load_d   = load_q;
        wb_d     = wb_q;
        offset_d = offset_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d  = S_BASE;
                list_d   = reg_list;
                base_d   = base_reg;
                load_d   = is_load;
                wb_d     = writeback;
                offset_d = 7'd0;
            end
            S_BASE: begin
                if (abort_w)             state_d = S_IDLE;
                else if (list_q != 16'd0) state_d = S_XFER;
                else                     state_d = S_DONE;
            end
            S_XFER: begin
                if (abort_w) begin
                    state_d = S_IDLE;
                end else if (mem_ready) begin
                    list_d   = list_q & ~(16'd1 << cur_idx);
                    offset_d = offset_q + 7'(WORD_BYTES);
                    if (list_d == 16'd0) state_d = wb_q ? S_WB : S_DONE;
                end
            end
            S_WB:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // After the last beat offset_q equals popcount*WORD_BYTES, which is what WB reports.
    always_comb begin
        mux_a_sel   = 3'd0;
        reg_addr    = 4'd0;
        xfer_valid  = 1'b0;
        rf_write    = 1'b0;
        addr_offset = offset_q;
        busy        = 1'b1;
        base_wb     = 1'b0;
        done        = 1'b0;
        case (state_q)
            S_IDLE: begin
                mux_a_sel   = 3'd1;
                addr_offset = 7'd0;
                busy        = 1'b0;
            end
            S_BASE: reg_addr = base_q;
            S_XFER: begin
                mux_a_sel  = (cur_idx == 4'd15) ? 3'd2 : 3'd3;
                reg_addr   = cur_idx;
                xfer_valid = 1'b1;
                rf_write   = load_q & mem_ready;
            end
            S_WB: begin
                reg_addr = base_q;
                base_wb  = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_reg_list_sequencer.sv
// Directed, table-driven bench for reg_list_sequencer: one row per clock cycle, plus reset corner sequences.
module tb_reg_list_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] reg_list = 16'd0;
    logic [3:0]  base_reg = 4'd0;
    logic        is_load = 1'b0;
    logic        writeback = 1'b0;
    logic        mem_ready = 1'b0;
    logic [2:0]  mux_a_sel;
    logic [3:0]  reg_addr;
    logic        xfer_valid, rf_write, busy, base_wb, done;
    logic [6:0]  addr_offset;
`ifdef REG_LIST_SEQUENCER_ABORT_EN
    logic        abort = 1'b0;
`endif

    int total = 0;
    int bad = 0;

    reg_list_sequencer #(.WORD_BYTES(4)) dut (
        .clk(clk), .reset(reset), .start(start), .reg_list(reg_list),
        .base_reg(base_reg), .is_load(is_load), .writeback(writeback),
        .mem_ready(mem_ready),
`ifdef REG_LIST_SEQUENCER_ABORT_EN
        .abort(abort),
`endif
        .mux_a_sel(mux_a_sel), .reg_addr(reg_addr), .xfer_valid(xfer_valid),
        .rf_write(rf_write), .addr_offset(addr_offset), .busy(busy),
        .base_wb(base_wb), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [15:0] lst;
        logic [3:0]  br;
        logic        ld, wb, rdy;
        logic [2:0]  e_mux;
        logic [3:0]  e_addr;
        logic        e_xv, e_rfw;
        logic [6:0]  e_off;
        logic        e_busy, e_bwb, e_done;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input logic st, input logic [15:0] lst, input logic [3:0] br,
                     input logic ld, input logic wb, input logic rdy,
                     input logic [2:0] mx, input logic [3:0] ad, input logic xv,
                     input logic rfw, input logic [6:0] off, input logic bsy,
                     input logic bwb, input logic dn);
        vec_t r;
        r.st = st; r.lst = lst; r.br = br; r.ld = ld; r.wb = wb; r.rdy = rdy;
        r.e_mux = mx; r.e_addr = ad; r.e_xv = xv; r.e_rfw = rfw; r.e_off = off;
        r.e_busy = bsy; r.e_bwb = bwb; r.e_done = dn;
        vecs.push_back(r);
    endtask

    task automatic check(input string name, input logic [2:0] mx, input logic [3:0] ad,
                         input logic xv, input logic rfw, input logic [6:0] off,
                         input logic bsy, input logic bwb, input logic dn);
        logic [18:0] act, exp;
        act = {mux_a_sel, reg_addr, xfer_valid, rf_write, addr_offset, busy, base_wb, done};
        exp = {mx, ad, xv, rfw, off, bsy, bwb, dn};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got sel=%0d addr=%0d xv=%b rfw=%b off=%0d busy=%b bwb=%b done=%b, want sel=%0d addr=%0d xv=%b rfw=%b off=%0d busy=%b bwb=%b done=%b",
                     name, mux_a_sel, reg_addr, xfer_valid, rf_write, addr_offset, busy, base_wb, done,
                     mx, ad, xv, rfw, off, bsy, bwb, dn);
        end
    endtask

    task automatic drive(input logic st, input logic [15:0] lst, input logic [3:0] br,
                         input logic ld, input logic wb, input logic rdy);
        start = st; reg_list = lst; base_reg = br; is_load = ld; writeback = wb; mem_ready = rdy;
    endtask

    initial begin
        // list 0x0015, base 2, load, wb: BASE, r0/r2/r4 at 0/4/8, WB at 12, DONE
        //  st lst      br ld wb rdy  sel ad xv rfw off bsy bwb dn
        v(1, 16'h0015, 2, 1, 1, 1,   1,  0, 0, 0,  0,  0,  0,  0);
        v(0, 16'h0000, 0, 0, 0, 1,   0,  2, 0, 0,  0,  1,  0,  0);
        v(0, 16'h0000, 0, 0, 0, 1,   3,  0, 1, 1,  0,  1,  0,  0);
        v(0, 16'h0000, 0, 0, 0, 1,   3,  2, 1, 1,  4,  1,  0,  0);
        v(0, 16'h0000, 0, 0, 0, 1,   3,  4, 1, 1,  8,  1,  0,  0);
        v(0, 16'h0000, 0, 0, 0, 1,   0,  2, 0, 0, 12,  1,  1,  0);
        v(0, 16'h0000, 0, 0, 0, 1,   0,  0, 0, 0, 12,  1,  0,  1);
        v(0, 16'h0000, 0, 0, 0, 1,   1,  0, 0, 0,  0,  0,  0,  0);
        // list 0x8001 store, no wb: r0 sel 3, r15 sel 2; start in DONE ignored
        v(1, 16'h8001, 5, 0, 0, 1,   1,  0, 0, 0,  0,  0,  0,  0);
        v(0, 16'h0000, 0, 0, 0, 1,   0,  5, 0, 0,  0,  1,  0,  0);
        v(0, 16'h0000, 0, 0, 0, 1,   3,  0, 1, 0,  0,  1,  0,  0);
        v(0, 16'h0000, 0, 0, 0, 1,   2, 15, 1, 0,  4,  1,  0,  0);
        v(1, 16'h00FF, 1, 1, 1, 1,   0,  0, 0, 0,  8,  1,  0,  1);
        v(0, 16'h0000, 0, 0, 0, 1,   1,  0, 0, 0,  0,  0,  0,  0);
        // empty list with wb: BASE then DONE only
        v(1, 16'h0000, 3, 1, 1, 1,   1,  0, 0, 0,  0,  0,  0,  0);
        v(0, 16'h0000, 0, 0, 0, 1,   0,  3, 0, 0,  0,  1,  0,  0);
        v(0, 16'h0000, 0, 0, 0, 1,   0,  0, 0, 0,  0,  1,  0,  1);
        v(0, 16'h0000, 0, 0, 0, 1,   1,  0, 0, 0,  0,  0,  0,  0);
        // list 0x0006, stall 3 cycles on r1 (start pulses ignored), then r2 at 4
        v(1, 16'h0006, 0, 1, 0, 1,   1,  0, 0, 0,  0,  0,  0,  0);
        v(0, 16'h0000, 0, 0, 0, 0,   0,  0, 0, 0,  0,  1,  0,  0);
        v(1, 16'hFFFF, 7, 1, 1, 0,   3,  1, 1, 0,  0,  1,  0,  0);
        v(0, 16'h0000, 0, 0, 0, 0,   3,  1, 1, 0,  0,  1,  0,  0);
        v(1, 16'hFFFF, 7, 1, 1, 0,   3,  1, 1, 0,  0,  1,  0,  0);
        v(0, 16'h0000, 0, 0, 0, 1,   3,  1, 1, 1,  0,  1,  0,  0);
        v(0, 16'h0000, 0, 0, 0, 1,   3,  2, 1, 1,  4,  1,  0,  0);
        v(0, 16'h0000, 0, 0, 0, 1,   0,  0, 0, 0,  8,  1,  0,  1);
        v(0, 16'h0000, 0, 0, 0, 1,   1,  0, 0, 0,  0,  0,  0,  0);

        #12;
        check("reset_values", 1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].st, vecs[i].lst, vecs[i].br, vecs[i].ld, vecs[i].wb, vecs[i].rdy);
            #1;
            check($sformatf("row%0d", i), vecs[i].e_mux, vecs[i].e_addr, vecs[i].e_xv,
                  vecs[i].e_rfw, vecs[i].e_off, vecs[i].e_busy, vecs[i].e_bwb, vecs[i].e_done);
        end

        // Reset mid-XFER with a start pending: outputs drop at once, start honoured from IDLE only.
        @(negedge clk);
        drive(1, 16'h00F0, 6, 1, 1, 1);
        @(negedge clk);
        drive(0, 16'h0000, 0, 0, 0, 1);
        @(negedge clk);
        drive(1, 16'h0100, 9, 1, 0, 1);
        #1;
        check("mid_xfer_before_rst", 3, 4, 1, 1, 0, 1, 0, 0);
        #1;
        reset = 1'b1;
        #1;
        check("async_rst_mid_xfer", 1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("held_in_reset", 1, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        @(negedge clk);
        drive(0, 16'h0000, 0, 0, 0, 1);
        #1;
        check("start_after_rst_base", 0, 9, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        #1;
        check("new_list_xfer", 3, 8, 1, 1, 0, 1, 0, 0);
        @(negedge clk);
        #1;
        check("new_list_done", 0, 0, 0, 0, 4, 1, 0, 1);
        @(negedge clk);
        #1;
        check("back_to_idle", 1, 0, 0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_list_sequencer.md
REG_LIST_SEQUENCER -- requirements
Module: reg_list_sequencer

Interface
REQ-001 The block SHALL have parameter WORD_BYTES, default 4, meaning the byte stride added to addr_offset per transferred register.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, request to begin a block transfer; sampled only in IDLE.
REQ-005 The block SHALL have port reg_list, input, 16, register bitmap (bit n = register n); captured on accepted start.
REQ-006 The block SHALL have port base_reg, input, 4, base register number; captured on accepted start.
REQ-007 The block SHALL have port is_load, input, 1, 1 = load (register-file write), 0 = store; captured on accepted start.
REQ-008 The block SHALL have port writeback, input, 1, 1 = base update after the transfers; captured on accepted start.
REQ-009 The block SHALL have port mem_ready, input, 1, memory accepts or returns the current transfer this cycle.
REQ-010 The block SHALL have port mux_a_sel, output, 3, select code for the port-A address mux: 0 base, 1 instruction field, 2 forced R15, 3 list register.
REQ-011 The block SHALL have port reg_addr, output, 4, register number of the current transfer (base_reg in BASE and WB).
REQ-012 The block SHALL have port xfer_valid, output, 1, current transfer is presented to memory.
REQ-013 The block SHALL have port rf_write, output, 1, register-file write enable for load data.
REQ-014 The block SHALL have port addr_offset, output, 7, byte offset of the current transfer from the base.
REQ-015 The block SHALL have ports busy, base_wb and done, outputs, 1 each: not IDLE; base write-back strobe; one-cycle completion pulse.

Function
REQ-016 The state machine SHALL have states IDLE, BASE, XFER, WB and DONE.
REQ-017 In IDLE, start=1 SHALL capture the inputs and go to BASE; start while not IDLE SHALL be ignored.
REQ-018 BASE SHALL last one cycle with mux_a_sel=0, then go to XFER if the captured list is non-zero, else to DONE.
REQ-019 XFER SHALL present registers in ascending order, lowest set bit first, one register per accepted transfer.
REQ-020 In XFER: xfer_valid=1; mux_a_sel=2 when the current register is 15, else 3; rf_write=is_load AND mem_ready.
REQ-021 mem_ready=0 in XFER SHALL stall, holding reg_addr, addr_offset and mux_a_sel unchanged.
REQ-022 On mem_ready=1 the current bit SHALL be cleared and addr_offset SHALL advance by WORD_BYTES; after the last bit the FSM SHALL go to WB if writeback=1, else to DONE.
REQ-023 WB SHALL last one cycle with base_wb=1, mux_a_sel=0, and addr_offset=popcount(reg_list)*WORD_BYTES.
REQ-024 DONE SHALL last one cycle with done=1, then return to IDLE; start in DONE SHALL be ignored.
REQ-025 Outside XFER, xfer_valid and rf_write SHALL be 0; in IDLE, mux_a_sel SHALL be 1.
REQ-026 Latency for N set bits with mem_ready held high SHALL be 1+N+(writeback?1:0)+1 cycles from start to done, inclusive.
REQ-027 A base register that also appears in the list SHALL be transferred normally; when writeback=1 base_wb still occurs.

Reset
REQ-028 Reset SHALL force IDLE asynchronously, from any state including mid-XFER, discarding the captured list.
REQ-029 Reset values: mux_a_sel=1, reg_addr=0, addr_offset=0, xfer_valid=0, rf_write=0, base_wb=0, done=0, busy=0.

Configuration
REQ-030 With macro REG_LIST_SEQUENCER_ABORT_EN defined, an input abort (1 bit) SHALL exist; abort=1 in BASE or XFER SHALL go to IDLE next cycle with no WB and no done pulse.
REQ-031 With REG_LIST_SEQUENCER_ABORT_EN undefined, no abort port SHALL exist and only reset can terminate a sequence.

Verification
REQ-032 Start with list=0x0015, base=2, load, wb=1, ready=1 -> reg_addr 0,2,4 at offsets 0,4,8; rf_write on each; WB offset=12; done 6 cycles after start.
REQ-033 Start with list=0x8001, store, wb=0 -> reg 0 with sel=3, then reg 15 with sel=2; rf_write stays 0; no base_wb.
REQ-034 Start with list=0x0000, wb=1 -> BASE then DONE; no xfer_valid and no base_wb.
REQ-035 List=0x0006 with mem_ready low for 3 cycles on reg 1 -> reg_addr=1 and offset=0 held; then reg 2 at offset 4.
REQ-036 Reset asserted mid-XFER with start pulsed during busy -> all outputs at reset values immediately; the new start is taken only from IDLE.
